// File: rtl/mmio_uart_tx_if.sv
// MEM-stage bus bundle for the memory-mapped UART transmitter.
// The core drives strobes, address and store data; the peripheral returns Hit and ReadData.
`timescale 1ns/1ps

interface mmio_uart_tx_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        input  ReadData, Hit
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        output ReadData, Hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to DATA_ADDR fill a byte FIFO that a
// start/data/stop serializer drains; loads from STATUS_ADDR report FIFO and line state.
`timescale 1ns/1ps

module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] DATA_ADDR    = 32'h1001_0040,
    parameter logic [31:0] STATUS_ADDR  = 32'h1001_0044
) (
    input  logic               clk,
    input  logic               reset,
    mmio_uart_tx_if.slave      bus,
    output logic               tx,
    output logic               Busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [3:0]        DEPTH_C   = 4'(FIFO_DEPTH);
    localparam logic [3:0]        CNT_ONE   = 4'd1;
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    txState_t          state_q, state_d;
    logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]        bitIdx_q, bitIdx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic [7:0]        fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [3:0]        count_q, count_d;
    logic              overflow_q, overflow_d;

    logic dataSel;
    logic statusSel;
    logic pushReq;
    logic pushOk;
    logic ovfSet;
    logic clearOvf;
    logic fifoFull;
    logic fifoEmpty;
    logic bitDone;
    logic pop;

    // Address decode is purely combinational so the MEM stage can mux ReadData in the same cycle.
    assign dataSel   = (bus.Address == DATA_ADDR);
    assign statusSel = (bus.Address == STATUS_ADDR);
    assign bus.Hit   = dataSel | statusSel;

    assign fifoFull  = (count_q == DEPTH_C);
    assign fifoEmpty = (count_q == 4'd0);
    assign bitDone   = (baudCnt_q == BAUD_LAST);

    assign pushReq   = bus.MemWrite & dataSel;
    assign clearOvf  = bus.MemWrite & statusSel & bus.WriteData[2];
    assign pushOk    = pushReq & (~fifoFull | pop);
    assign ovfSet    = pushReq & fifoFull & ~pop;

    assign Busy = (state_q != IDLE) | ~fifoEmpty;
    assign tx   = tx_q;

    always_comb begin
        bus.ReadData = 32'h0;
        if (bus.MemRead && statusSel) begin
            bus.ReadData = {25'b0, count_q[2:0], 1'b0, overflow_q, fifoFull, Busy};
        end
    end

    // Serializer: pops from the FIFO in IDLE, or straight out of STOP so frames abut.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                baudCnt_d = '0;
                if (!fifoEmpty) begin
                    pop     = 1'b1;
                    shift_d = fifoMem_q[head_q];
                    state_d = START;
                end
            end
            START: begin
                if (bitDone) begin
                    baudCnt_d = '0;
                    bitIdx_d  = 3'd0;
                    state_d   = DATA;
                end else begin
                    baudCnt_d = baudCnt_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (bitDone) begin
                    baudCnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bitIdx_d  = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + BAUD_ONE;
                end
            end
            STOP: begin
                if (bitDone) begin
                    baudCnt_d = '0;
                    if (!fifoEmpty) begin
                        pop     = 1'b1;
                        shift_d = fifoMem_q[head_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + BAUD_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                baudCnt_d = '0;
            end
        endcase

        // tx is registered from the next state so the pin never glitches between states.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        head_d     = pop    ? head_q + PTR_ONE : head_q;
        tail_d     = pushOk ? tail_q + PTR_ONE : tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case ({pushOk, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (clearOvf) begin
            overflow_d = 1'b0;
        end else if (ovfSet) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baudCnt_q  <= '0;
            bitIdx_q   <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem_q[tail_q] <= bus.WriteData[7:0];
        end
    end

endmodule
